spmv_ctrl: RTL
==============

// Module: spmv_ctrl
// PURPOSE
//  CSR sequencer in front of SpMV_core. On i_start: loads 17 row pointers from ptr memory and packs them onto o_row_ptr.
//  Then streams each nonzero: reads val/col, reads x[col], and presents A=val, B=x with the element index on o_count.
//  Holds o_core_start until the core reports done, then pulses o_done. Sits between host/CSR memories and SpMV_core.
// PARAMETERS
//  ROWS        16  matrix rows; row_ptr has ROWS+1 entries
//  PTR_W       8   row_ptr entry / element index width
//  DATA_W      16  fp16 operand width
//  COL_W       4   column index width (x has 2^COL_W entries)
//  ELEM_CYCLES 4   cycles per element on the core interface (>=3)
// PORTS
//  i_clk          in   1              clock, rising edge
//  i_rstn         in   1              synchronous, active-low reset
//  i_start        in   1              start request; sampled only in IDLE
//  o_busy         out  1              high from accepted start until o_done cycle inclusive
//  o_done         out  1              1-cycle pulse at end of job
//  o_error        out  1              set with o_done if row_ptr non-monotonic; cleared on next accepted start
//  o_ptr_en       out  1              ptr memory read enable
//  o_ptr_addr     out  5              ptr memory address, 0..ROWS
//  i_ptr_data     in   PTR_W          ptr data, valid 1 cycle after o_ptr_en
//  o_val_en       out  1              val/col memory read enable (shared address)
//  o_val_addr     out  PTR_W          nonzero index
//  i_val_data     in   DATA_W         A value, valid 1 cycle after o_val_en
//  i_col_data     in   COL_W          column index, valid 1 cycle after o_val_en
//  o_x_en         out  1              x memory read enable
//  o_x_addr       out  COL_W          x index
//  i_x_data       in   DATA_W         x value, valid 1 cycle after o_x_en
//  o_core_start   out  1              drives SpMV_core i_start
//  o_read_data_A  out  DATA_W         drives SpMV_core i_read_data_A
//  o_read_data_B  out  DATA_W         drives SpMV_core i_read_data_B
//  o_count        out  PTR_W          drives SpMV_core count
//  o_row_ptr      out  (ROWS+1)*PTR_W drives row_ptr; entry r at [PTR_W*r +: PTR_W]
//  i_core_done    in   1              SpMV_core o_done
// BEHAVIOUR
//  Reset: every output 0, FSM->IDLE. Reset mid-job aborts immediately; no o_done, core start drops next edge.
//  FSM: IDLE -> LOAD_PTR -> (nnz==0 | error ? FINISH : STREAM) -> WAIT_CORE -> FINISH -> IDLE.
//  IDLE: start accepted when i_start=1; o_busy rises next cycle. i_start while busy is ignored.
//  LOAD_PTR: one ptr read per cycle, addr 0..ROWS. Entry r is written to o_row_ptr one cycle later; total ROWS+2 cycles.
//   A non-monotonic entry (ptr[r] < ptr[r-1]) sets the error flag; the sweep still completes. nnz = ptr[ROWS].
//  STREAM: element k = 0..nnz-1 in ELEM_CYCLES-cycle slots, phase p counts 0..ELEM_CYCLES-1:
//   p0: o_val_en=1, o_val_addr=k.  p1: latch val and col; o_x_en=1, o_x_addr=col.
//   p2: latch x.  p(ELEM_CYCLES-1): o_read_data_A, o_read_data_B and o_count=k update on the same edge.
//   Core-side outputs are stable for exactly ELEM_CYCLES cycles per element.
//   o_core_start rises on the edge element 0 is presented, never earlier.
//   The last element is held ELEM_CYCLES cycles, then the FSM enters WAIT_CORE; A, B and count hold their last values.
//  WAIT_CORE: o_core_start stays 1 until i_core_done=1, drops the following edge; FSM -> FINISH.
//   i_core_done seen in STREAM is latched and honoured at WAIT_CORE entry.
//  FINISH: o_done=1 for one cycle with o_busy=1; o_row_ptr holds until the next start. nnz==0 never starts the core.
//  Memory enables are 1 only in the listed cycles; addresses are don't-care otherwise but held.
//  nnz up to 2^PTR_W-1; o_count and element counter are PTR_W wide with no wrap inside a job.
// STRUCTURE
//  Shared package spmv_pkg: state encoding, ROWS/PTR_W/DATA_W/COL_W constants, ROW_PTR_W=(ROWS+1)*PTR_W.
//  One natural sub-module: spmv_elem_fetch (phase counter + val/col -> x fetch pipeline, emits A/B/count strobe).
// TESTING
//  1 ptr memory = 0,0,1,2,2,3,4,4,4,7,7,7,7,9,9,9,10 -> after 18 cycles
//    o_row_ptr==136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00; 10 elements streamed.
//  2 val[k]=16'h4C00 (16.0), col[k]=k%16, x[i]=16'h4000 (2.0); x[1]=16'h4700 (7.0) with val[1]=16'h4200 (3.0)
//    -> count 0..9, each held 4 cycles; A/B pairs match memories; o_x_addr==col on every p1.
//  3 core stub asserts i_core_done 5 cycles after last element -> o_core_start falls next edge;
//    o_done 1-cycle pulse; o_busy low afterwards.
//  4 all ptr entries 0 -> no val/x reads, o_core_start never 1, o_done pulse 19 cycles after start, o_error=0.
//  5 ptr[5]=1 < ptr[4]=2 -> o_error=1 with o_done, no stream; next clean start clears o_error.
//  6 i_rstn=0 during element 4 -> next cycle all outputs 0, FSM IDLE; restart completes normally. i_start held high mid-job ignored.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared constants and FSM encoding for the CSR SpMV sequencer.
package spmv_pkg;

    localparam int ROWS        = 16;
    localparam int PTR_W       = 8;
    localparam int DATA_W      = 16;
    localparam int COL_W       = 4;
    localparam int ELEM_CYCLES = 4;

    localparam int ROW_PTR_W  = (ROWS + 1) * PTR_W;
    localparam int PTR_ADDR_W = 5;
    localparam int PHASE_W    = $clog2(ELEM_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_PTR,
        S_STREAM,
        S_WAIT_CORE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/spmv_elem_fetch.sv
// Per-element fetch pipeline: val/col read, dependent x read, then present A/B/count to the core.
// Latency: element k fetch starts on slot phase 0 and is presented on the edge ending phase ELEM_CYCLES-1.
// Backpressure: none; memories have fixed 1-cycle read latency and the core accepts one element per slot.
module spmv_elem_fetch
    import spmv_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic [PTR_W-1:0]  i_nnz,
    input  logic [DATA_W-1:0] i_val_data,
    input  logic [COL_W-1:0]  i_col_data,
    input  logic [DATA_W-1:0] i_x_data,
    output logic              o_val_en,
    output logic [PTR_W-1:0]  o_val_addr,
    output logic              o_x_en,
    output logic [COL_W-1:0]  o_x_addr,
    output logic [DATA_W-1:0] o_read_data_A,
    output logic [DATA_W-1:0] o_read_data_B,
    output logic [PTR_W-1:0]  o_count,
    output logic              o_present,
    output logic              o_slot_done
);

    localparam logic [PHASE_W-1:0] PH_VAL  = '0;
    localparam logic [PHASE_W-1:0] PH_COL  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_X    = PHASE_W'(2);
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(ELEM_CYCLES - 1);
    // With a 3-cycle slot the x word arrives on the presentation edge itself.
    localparam bit X_BYPASS = (ELEM_CYCLES == 3);

    logic [PHASE_W-1:0] phase;
    logic [PTR_W-1:0]   idx;
    logic [DATA_W-1:0]  val_q;
    logic [DATA_W-1:0]  x_q;
    logic [COL_W-1:0]   col_q;
    logic               fetch;

    // Slot idx == nnz is the trailing hold slot: no reads, last element stays on the core bus.
    assign fetch       = i_run && (idx < i_nnz);
    assign o_val_en    = fetch && (phase == PH_VAL);
    assign o_val_addr  = idx;
    assign o_x_en      = fetch && (phase == PH_COL);
    assign o_x_addr    = o_x_en ? i_col_data : col_q;
    assign o_present   = fetch && (phase == PH_LAST);
    assign o_slot_done = i_run && !fetch && (phase == PH_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            phase         <= '0;
            idx           <= '0;
            val_q         <= '0;
            x_q           <= '0;
            col_q         <= '0;
            o_read_data_A <= '0;
            o_read_data_B <= '0;
            o_count       <= '0;
        end else if (i_clear) begin
            phase <= '0;
            idx   <= '0;
        end else if (i_run) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (fetch && (phase == PH_COL)) begin
                val_q <= i_val_data;
                col_q <= i_col_data;
            end
            if (fetch && (phase == PH_X)) begin
                x_q <= i_x_data;
            end
            if (o_present) begin
                o_read_data_A <= val_q;
                o_read_data_B <= X_BYPASS ? i_x_data : x_q;
                o_count       <= idx;
                idx           <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmv_ctrl.sv
// CSR sequencer: loads row pointers, streams nonzeros with their x operand into SpMV_core, waits for core done.
// Latency: ROWS+2 cycles pointer sweep, ELEM_CYCLES per nonzero plus one hold slot, then core wait and 1-cycle done.
// Backpressure: none on memories (fixed 1-cycle reads); core side holds o_core_start until i_core_done.
module spmv_ctrl
    import spmv_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_ptr_en,
    output logic [PTR_ADDR_W-1:0] o_ptr_addr,
    input  logic [PTR_W-1:0]      i_ptr_data,
    output logic                  o_val_en,
    output logic [PTR_W-1:0]      o_val_addr,
    input  logic [DATA_W-1:0]     i_val_data,
    input  logic [COL_W-1:0]      i_col_data,
    output logic                  o_x_en,
    output logic [COL_W-1:0]      o_x_addr,
    input  logic [DATA_W-1:0]     i_x_data,
    output logic                  o_core_start,
    output logic [DATA_W-1:0]     o_read_data_A,
    output logic [DATA_W-1:0]     o_read_data_B,
    output logic [PTR_W-1:0]      o_count,
    output logic [ROW_PTR_W-1:0]  o_row_ptr,
    input  logic                  i_core_done
);

    localparam logic [PTR_ADDR_W-1:0] LOAD_LAST = PTR_ADDR_W'(ROWS + 1);
    localparam logic [PTR_ADDR_W-1:0] ADDR_MAX  = PTR_ADDR_W'(ROWS);

    state_t                state_q;
    state_t                state_d;
    logic [PTR_ADDR_W-1:0] load_cnt;
    logic [PTR_W-1:0]      prev_ptr;
    logic [PTR_W-1:0]      nnz;
    logic [ROW_PTR_W-1:0]  row_ptr_q;
    logic                  err_acc;
    logic                  error_q;
    logic                  done_seen;
    logic                  core_start_q;
    logic                  start_acc;
    logic                  load_last;
    logic                  new_err;
    logic                  core_ack;
    logic                  present;
    logic                  slot_done;

    assign nnz       = row_ptr_q[PTR_W*ROWS +: PTR_W];
    assign start_acc = (state_q == S_IDLE) && i_start;
    assign load_last = (state_q == S_LOAD_PTR) && (load_cnt == LOAD_LAST);
    // load_cnt >= 2 means the entry arriving now has a predecessor to compare against.
    assign new_err   = (state_q == S_LOAD_PTR) && (load_cnt >= PTR_ADDR_W'(2)) &&
                       (i_ptr_data < prev_ptr);
    assign core_ack  = i_core_done || done_seen;

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_FINISH);
    assign o_error      = error_q;
    assign o_ptr_en     = (state_q == S_LOAD_PTR) && (load_cnt <= ADDR_MAX);
    assign o_ptr_addr   = (load_cnt > ADDR_MAX) ? ADDR_MAX : load_cnt;
    assign o_core_start = core_start_q;
    assign o_row_ptr    = row_ptr_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_LOAD_PTR;
            end
            S_LOAD_PTR: begin
                if (load_last) begin
                    if ((i_ptr_data == '0) || err_acc || new_err) state_d = S_FINISH;
                    else                                          state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (slot_done) state_d = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_ack) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            load_cnt     <= '0;
            prev_ptr     <= '0;
            row_ptr_q    <= '0;
            err_acc      <= 1'b0;
            error_q      <= 1'b0;
            done_seen    <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            if (start_acc) begin
                load_cnt  <= '0;
                err_acc   <= 1'b0;
                error_q   <= 1'b0;
                done_seen <= 1'b0;
            end
            if (state_q == S_LOAD_PTR) begin
                if (!load_last) load_cnt <= load_cnt + 1'b1;
                // Read issued at load_cnt = r returns while load_cnt = r+1.
                for (int r = 0; r <= ROWS; r++) begin
                    if (load_cnt == PTR_ADDR_W'(r + 1)) row_ptr_q[PTR_W*r +: PTR_W] <= i_ptr_data;
                end
                if (load_cnt != '0) prev_ptr <= i_ptr_data;
                if (new_err)        err_acc  <= 1'b1;
                if (load_last)      error_q  <= err_acc | new_err;
            end
            if ((state_q == S_STREAM) && i_core_done) done_seen    <= 1'b1;
            if ((state_q == S_STREAM) && present)     core_start_q <= 1'b1;
            if ((state_q == S_WAIT_CORE) && core_ack) core_start_q <= 1'b0;
        end
    end

    spmv_elem_fetch u_elem_fetch (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_run         (state_q == S_STREAM),
        .i_clear       (start_acc),
        .i_nnz         (nnz),
        .i_val_data    (i_val_data),
        .i_col_data    (i_col_data),
        .i_x_data      (i_x_data),
        .o_val_en      (o_val_en),
        .o_val_addr    (o_val_addr),
        .o_x_en        (o_x_en),
        .o_x_addr      (o_x_addr),
        .o_read_data_A (o_read_data_A),
        .o_read_data_B (o_read_data_B),
        .o_count       (o_count),
        .o_present     (present),
        .o_slot_done   (slot_done)
    );

endmodule
